// File: rtl/jb_rssi_sched.sv
// RSSI measurement window scheduler: issues accumulator load pulses
// on a period timer or external sync and captures per-user results.
module jb_rssi_sched #(
    parameter int unsigned N_USRS    = 4,
    parameter int unsigned CNT_BW    = 32,
    parameter int unsigned LOAD_HOLD = 4,
    parameter int unsigned SETTLE    = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clk_en,
    input  logic                 cfg_enable,
    input  logic                 cfg_mode,
    input  logic [CNT_BW-1:0]    cfg_period,
    input  logic                 ext_sync,
    output logic                 rssi_load,
    input  logic [N_USRS*32-1:0] rssi_value,
    input  logic                 rd_ack,
    output logic [N_USRS*32-1:0] res_value,
    output logic                 res_valid,
    output logic [7:0]           res_seq,
    output logic                 res_overrun,
    output logic                 sync_miss,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_PSETTLE,
        S_RUN,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    // cnt restarts at each load, so hold and settle ends are fixed counts
    localparam logic [CNT_BW-1:0] HOLD_END = CNT_BW'(LOAD_HOLD - 1);
    localparam logic [CNT_BW-1:0] SEQ_END  = CNT_BW'(LOAD_HOLD + SETTLE - 1);
    localparam logic [CNT_BW-1:0] P_MIN    = CNT_BW'(LOAD_HOLD + SETTLE + 1);
    localparam logic [CNT_BW-1:0] ONE      = CNT_BW'(1);

    state_t            state;
    state_t            nxt;
    logic [CNT_BW-1:0] cnt;
    logic [CNT_BW-1:0] peff;
    logic [CNT_BW-1:0] peff_m1_q;
    logic              mode_q;
    logic              stop_q;
    logic              en_armed;
    logic              sync_q;
    logic              start;
    logic              sync_rise;
    logic              timer_hit;
    logic              stopping;
    logic              hold_done;
    logic              seq_done;
    logic              enter_seq;

    // a window never ends before its own load/settle/capture completes
    assign peff      = (cfg_period > P_MIN) ? cfg_period : P_MIN;
    assign start     = (state == S_IDLE) && cfg_enable && en_armed;
    assign sync_rise = ext_sync && !sync_q;
    assign timer_hit = !mode_q && (cnt == peff_m1_q);
    assign stopping  = stop_q || !cfg_enable;
    assign hold_done = (cnt == HOLD_END);
    assign seq_done  = (cnt == SEQ_END);
    assign enter_seq = ((nxt == S_PRIME) && (state != S_PRIME))
                    || ((nxt == S_LOAD) && (state != S_LOAD));

    // next-state decode
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    nxt = S_PRIME;
            end
            S_PRIME: begin
                if (hold_done)
                    nxt = S_PSETTLE;
            end
            S_PSETTLE: begin
                if (seq_done)
                    nxt = stopping ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (!cfg_enable)
                    nxt = S_IDLE;
                else if (mode_q ? sync_rise : timer_hit)
                    nxt = S_LOAD;
            end
            S_LOAD: begin
                if (hold_done)
                    nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (seq_done)
                    nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (stopping)
                    nxt = S_IDLE;
                else if (timer_hit)
                    nxt = S_LOAD;
                else
                    nxt = S_RUN;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // state register with registered load strobe and busy flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            rssi_load <= 1'b0;
            busy      <= 1'b0;
        end else if (clk_en) begin
            state     <= nxt;
            rssi_load <= (nxt == S_PRIME) || (nxt == S_LOAD);
            busy      <= (nxt != S_IDLE);
        end
    end

    // window counter: zero on the first load cycle, free-running after
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clk_en) begin
            if (enter_seq)
                cnt <= '0;
            else if (nxt != S_IDLE)
                cnt <= cnt + ONE;
            else
                cnt <= '0;
        end
    end

    // edge history, config snapshot at start, stop request, sync drops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_armed  <= 1'b0;
            sync_q    <= 1'b0;
            mode_q    <= 1'b0;
            peff_m1_q <= '0;
            stop_q    <= 1'b0;
            sync_miss <= 1'b0;
        end else if (clk_en) begin
            en_armed <= !cfg_enable;
            sync_q   <= ext_sync;
            if (start) begin
                mode_q    <= cfg_mode;
                peff_m1_q <= peff - ONE;
                stop_q    <= 1'b0;
                sync_miss <= 1'b0;
            end else begin
                if ((state != S_IDLE) && !cfg_enable)
                    stop_q <= 1'b1;
                if (mode_q && sync_rise
                    && (state != S_IDLE) && (state != S_RUN))
                    sync_miss <= 1'b1;
            end
        end
    end

    // result capture; a capture outranks a same-cycle read acknowledge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_value   <= '0;
            res_valid   <= 1'b0;
            res_seq     <= 8'd0;
            res_overrun <= 1'b0;
        end else if (clk_en) begin
            if (state == S_CAPTURE) begin
                res_value <= rssi_value;
                res_valid <= 1'b1;
                res_seq   <= res_seq + 8'd1;
                if (res_valid && !rd_ack)
                    res_overrun <= 1'b1;
            end else begin
                if (rd_ack)
                    res_valid <= 1'b0;
                if (start)
                    res_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/jb_rssi_sched.md
JB_RSSI_SCHED -- requirements
Module: jb_rssi_sched

Interface
REQ-001 SHALL have parameter N_USRS, default 4, number of per-user RSSI accumulators served.
REQ-002 SHALL have parameter CNT_BW, default 32, width of the measurement period counter.
REQ-003 SHALL have parameter LOAD_HOLD, default 4, count of clk_en cycles that rssi_load is held high.
REQ-004 SHALL have parameter SETTLE, default 4, count of clk_en cycles waited after the load before capture.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port clk_en  in  1  qualifies every state, counter and register update.
REQ-008 SHALL have port cfg_enable  in  1  level; 1 runs the scheduler.
REQ-009 SHALL have port cfg_mode  in  1  0 = internal period timer, 1 = external sync.
REQ-010 SHALL have port cfg_period  in  CNT_BW  window length in clk_en cycles (timer mode).
REQ-011 SHALL have port ext_sync  in  1  frame/BFN sync level; its rising edge starts a window in sync mode.
REQ-012 SHALL have port rssi_load  out  1  load/clear request to the RSSI accumulator.
REQ-013 SHALL have port rssi_value  in  N_USRS x 32  accumulator results, packed by user.
REQ-014 SHALL have port rd_ack  in  1  software has consumed res_value.
REQ-015 SHALL have port res_value  out  N_USRS x 32  captured window results.
REQ-016 SHALL have port res_valid  out  1  res_value holds an unread result.
REQ-017 SHALL have port res_seq  out  8  capture sequence number.
REQ-018 SHALL have port res_overrun  out  1  sticky: an unread result was overwritten.
REQ-019 SHALL have port sync_miss  out  1  sticky: an ext_sync edge was dropped.
REQ-020 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-021 SHALL freeze all state when clk_en=0; every count below is in clk_en cycles.
REQ-022 SHALL implement states IDLE, PRIME, PSETTLE, RUN, LOAD, SETTLE and CAPTURE.
REQ-023 SHALL drive rssi_load=1 only in PRIME and LOAD; each of these states lasts exactly LOAD_HOLD cycles.
REQ-024 SHALL go IDLE->PRIME on the first cycle cfg_enable is seen 0->1, then PRIME->PSETTLE, and PSETTLE->RUN after SETTLE cycles, with no capture (this discards the partial pre-enable window).
REQ-025 SHALL, in timer mode, reset the period counter to 0 on the first cycle of PRIME or LOAD, increment it every cycle in all non-IDLE states, and enter LOAD when count = Peff-1 with Peff = max(cfg_period, LOAD_HOLD+SETTLE+1).
REQ-026 SHALL, in sync mode, detect an ext_sync rising edge by comparing against a registered copy, and enter LOAD from RUN on that edge.
REQ-027 SHALL ignore an ext_sync edge that arrives outside RUN and set sync_miss for it.
REQ-028 SHALL sequence LOAD->SETTLE->CAPTURE->RUN; CAPTURE lasts 1 cycle.
REQ-029 SHALL, in CAPTURE, copy rssi_value to res_value, set res_valid, and increment res_seq modulo 256 (255->0).
REQ-030 SHALL set res_overrun if res_valid=1 and rd_ack=0 in CAPTURE; the new value overwrites the old.
REQ-031 SHALL clear res_valid on rd_ack outside CAPTURE; in CAPTURE, the capture wins, res_valid stays 1 and no overrun is flagged.
REQ-032 SHALL, when cfg_enable=0 in RUN, go to IDLE on the next cycle without issuing a load.
REQ-033 SHALL, when cfg_enable=0 in PRIME/PSETTLE/LOAD/SETTLE/CAPTURE, complete the sequence (including any pending capture) and then go to IDLE.
REQ-034 SHALL clear res_overrun and sync_miss on the IDLE->PRIME transition.
REQ-035 SHALL sample cfg_mode and cfg_period only at the PRIME entry; changing them while busy has no effect.

Reset
REQ-036 SHALL, on resetn low, asynchronously force state IDLE, rssi_load=0, res_value=0, res_valid=0, res_seq=0, res_overrun=0, sync_miss=0, busy=0, period counter 0 and edge registers 0.
REQ-037 SHALL, on reset mid-window, drop any pending capture and require a fresh cfg_enable 0->1 before the next PRIME.

Verification
REQ-038 SHALL test timer mode with cfg_period=100, clk_en=1 -> rssi_load high 4 cycles every 100; first capture 9 cycles after the second load rise; res_seq=1.
REQ-039 SHALL test cfg_period=3 -> Peff=9, so rssi_load rises every 9 cycles.
REQ-040 SHALL test two captures with no rd_ack -> res_overrun=1, res_value = second window, res_seq=2.
REQ-041 SHALL test sync mode with an ext_sync edge during SETTLE -> no extra load, sync_miss=1; the next edge in RUN starts LOAD.
REQ-042 SHALL test rd_ack in the same cycle as CAPTURE -> res_valid stays 1 and res_overrun stays 0.
REQ-043 SHALL test clk_en toggling 1:3 with cfg_period=20 -> load spacing is 80 clk cycles; then cfg_enable=0 in LOAD -> capture still occurs, then IDLE with busy=0.
